float16_add_issue: RTL and testbench

Credit-based issue stage that sits directly upstream of `float16_adder` and wraps it. It buffers incoming operand pairs behind a valid/ready handshake and issues at most one pair per cycle into the adder's fixed-latency, non-stallable pipeline. It recaptures each result into an output FIFO with a valid/ready interface. Issue is throttled so that every in-flight result is guaranteed an output slot, letting downstream backpressure stall the adder path without losing data.

---
 rtl/float16_add_issue.sv | 118 +++++++++++
 tb/tb_float16_add_issue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float16_add_issue.sv
// float16_add_issue
//   Credit-based issue stage wrapped around a fixed-latency, non-stallable
//   float16 adder. Operand pairs are buffered in an input FIFO. At most one
//   pair per cycle is issued to the adder, and each result is recaptured into
//   an output FIFO. Issue is throttled so every in-flight result already owns
//   an output slot. This lets downstream backpressure stall the path without
//   losing data.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = input FIFO not full)
//   in_a, in_b          operands
//   add_a, add_b        registered operands driven to the adder
//   add_result          adder result, ADD_LATENCY cycles after add_a/add_b
//   out_valid/out_ready result handshake (out_valid = output FIFO not empty)
//   out_data            head result
//   out_special         head result exponent all ones (Inf/NaN)
//   busy                anything queued, in flight or awaiting readout
//   issue_cnt           pairs issued since reset, wraps modulo 2^16
module float16_add_issue #(
   parameter int FLOAT_LEN   = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADD_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FLOAT_LEN-1:0] in_a,
   input  logic [FLOAT_LEN-1:0] in_b,
   output logic [FLOAT_LEN-1:0] add_a,
   output logic [FLOAT_LEN-1:0] add_b,
   input  logic [FLOAT_LEN-1:0] add_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLOAT_LEN-1:0] out_data,
   output logic                 out_special,
   output logic                 busy,
   output logic [15:0]          issue_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   // Wide enough for inflight + out_count, which never exceeds FIFO_DEPTH.
   localparam int CW = AW + 2;
   localparam logic [AW:0]   DEPTH_P = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [FLOAT_LEN-1:0] in_mem_a [FIFO_DEPTH];
   logic [FLOAT_LEN-1:0] in_mem_b [FIFO_DEPTH];
   logic [FLOAT_LEN-1:0] out_mem  [FIFO_DEPTH];

   logic [AW:0]          in_wr, in_rd, out_wr, out_rd;
   logic [AW:0]          in_count, out_count;
   logic [CW-1:0]        inflight;
   logic [CW-1:0]        committed;
   logic [ADD_LATENCY:0] tag;

   logic in_empty, push_in, issue, capture, pop_out;

   always_comb begin
      in_count  = in_wr - in_rd;
      out_count = out_wr - out_rd;
      in_empty  = (in_wr == in_rd);
      in_ready  = (in_count != DEPTH_P);
      out_valid = (out_wr != out_rd);
      push_in   = in_valid && in_ready;
      pop_out   = out_valid && out_ready;
      capture   = tag[ADD_LATENCY];
      // Slots already promised to results. A capture moves one unit from
      // inflight to out_count, so only the same-cycle pop changes the total.
      committed = inflight + CW'(out_count) - CW'(pop_out);
      issue     = !in_empty && (committed < DEPTH_C);
      out_data  = out_mem[out_rd[AW-1:0]];
      // Gated so stale storage never shows through while the FIFO is empty.
      out_special = out_valid && (&out_data[FLOAT_LEN-2 -: 5]);
      busy      = !in_empty || (inflight != '0) || out_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_wr     <= '0;
         in_rd     <= '0;
         out_wr    <= '0;
         out_rd    <= '0;
         inflight  <= '0;
         tag       <= '0;
         add_a     <= '0;
         add_b     <= '0;
         issue_cnt <= '0;
      end else begin
         if (push_in) in_wr <= in_wr + 1'b1;
         if (issue) begin
            in_rd     <= in_rd + 1'b1;
            add_a     <= in_mem_a[in_rd[AW-1:0]];
            add_b     <= in_mem_b[in_rd[AW-1:0]];
            issue_cnt <= issue_cnt + 16'd1;
         end
         tag <= {tag[ADD_LATENCY-1:0], issue};
         if (capture) out_wr <= out_wr + 1'b1;
         if (pop_out) out_rd <= out_rd + 1'b1;
         case ({issue, capture})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Storage arrays are not reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push_in) begin
         in_mem_a[in_wr[AW-1:0]] <= in_a;
         in_mem_b[in_wr[AW-1:0]] <= in_b;
      end
      if (capture) out_mem[out_wr[AW-1:0]] <= add_result;
   end

endmodule

// File: tb/tb_float16_add_issue.sv
// Testbench for float16_add_issue. It contains a behavioural float16 adder
// (real arithmetic, ADD_LATENCY-deep pipeline) standing in for the external
// adder. A scoreboard queue holds expected sums in acceptance order. Outputs
// and acceptances are sampled on the falling edge. Inputs change 1 ns after
// the rising edge.
module tb_float16_add_issue;

   localparam int FLOAT_LEN   = 16;
   localparam int FIFO_DEPTH  = 4;
   localparam int ADD_LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] in_a, in_b, add_a, add_b, add_result;
   logic        out_valid, out_ready, out_special, busy;
   logic [15:0] out_data, issue_cnt;

   always #5 clk = ~clk;

   float16_add_issue #(
      .FLOAT_LEN  (FLOAT_LEN),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADD_LATENCY(ADD_LATENCY)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_special(out_special),
      .busy       (busy),
      .issue_cnt  (issue_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- float16 <-> real helpers ----------------
   function automatic real h2r(input logic [15:0] h);
      real m;
      int  e;
      e = int'(h[14:10]);
      m = real'(h[9:0]);
      if (e == 0) begin m = m / 1024.0; e = -14; end
      else        begin m = 1.0 + m / 1024.0; e = e - 15; end
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return h[15] ? -m : m;
   endfunction

   function automatic logic [15:0] r2h(input real x);
      logic s;
      real  ax;
      int   e, mi;
      s  = (x < 0.0);
      ax = s ? -x : x;
      if (ax == 0.0) return {s, 15'h0};
      if (ax >= 65520.0) return {s, 5'h1F, 10'h0};
      e = 0;
      while (ax >= 2.0) begin ax = ax / 2.0; e++; end
      while (ax < 1.0 && e > -14) begin ax = ax * 2.0; e--; end
      if (ax < 1.0) begin
         mi = $rtoi(ax * 1024.0 + 0.5);
         return {s, 15'(mi)};
      end
      mi = $rtoi((ax - 1.0) * 1024.0 + 0.5);
      if (mi == 1024) begin mi = 0; e++; end
      if (e > 15) return {s, 5'h1F, 10'h0};
      return {s, 5'(e + 15), 10'(mi)};
   endfunction

   function automatic logic [15:0] hadd(input logic [15:0] a, input logic [15:0] b);
      logic a_inf, b_inf, a_nan, b_nan;
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
      if (a_nan || b_nan) return 16'h7E00;
      if (a_inf && b_inf) return (a[15] == b[15]) ? a : 16'h7E00;
      if (a_inf) return a;
      if (b_inf) return b;
      return r2h(h2r(a) + h2r(b));
   endfunction

   // ---------------- behavioural adder ----------------
   logic [15:0] pipe [ADD_LATENCY];
   always @(posedge clk) begin
      pipe[0] <= hadd(add_a, add_b);
      for (int unsigned i = 1; i < ADD_LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign add_result = pipe[ADD_LATENCY-1];

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum;
   } exp_t;

   exp_t exp_q[$];
   int   exp_issue = 0;
   int   n_out     = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_issue = 0;
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back('{a: in_a, b: in_b, sum: hadd(in_a, in_b)});
            exp_issue++;
         end
         if (out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h, expected no result", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e.sum));
               check("out_special", 32'(out_special), 32'(&e.sum[14:10]));
               if (e.sum[14:10] != 5'h1F) begin
                  real d;
                  d = h2r(out_data) - (h2r(e.a) + h2r(e.b));
                  if (d < 0.0) d = -d;
                  check("sum_within_0p2", 32'(d <= 0.2), 32'd1);
               end
            end
         end
         check("credit_bound",
               32'((int'(dut.inflight) + int'(dut.out_count)) <= FIFO_DEPTH), 32'd1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin step(); n++; end
      check("drain_in_time", 32'(busy), 32'd0);
   endtask

   function automatic logic [15:0] rand_h();
      real r;
      r = (real'($urandom_range(20000)) - 10000.0) / 100.0;
      return r2h(r);
   endfunction

   // Single operation from idle with out_ready = 1; checks exact latency.
   task automatic single_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_sum, input logic exp_spec);
      logic [15:0] base;
      base      = issue_cnt;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      step();                      // E0: accepted
      in_valid = 1'b0;
      step();                      // E0+1: issued
      check("issue_add_a", 32'(add_a), 32'(a));
      check("issue_add_b", 32'(add_b), 32'(b));
      check("issue_cnt_inc", 32'(issue_cnt), 32'(base + 16'd1));
      step();
      step();                      // E0+3
      check("out_valid_early", 32'(out_valid), 32'd0);
      step();                      // E0+4
      check("out_valid_lat", 32'(out_valid), 32'd1);
      check("head_data", 32'(out_data), 32'(exp_sum));
      check("head_special", 32'(out_special), 32'(exp_spec));
      check("busy_holding", 32'(busy), 32'd1);
      step();                      // E0+5: popped
      check("busy_cleared", 32'(busy), 32'd0);
      check("out_valid_cleared", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int stalls, accepts, stale;
      logic [15:0] base;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_special", 32'(out_special), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
      check("rst_add_a", 32'(add_a), 32'd0);
      check("rst_add_b", 32'(add_b), 32'd0);
      rst_n = 1'b1;
      step();

      // 1.0 + 2.0
      single_op(16'h3C00, 16'h4000, 16'h4200, 1'b0);
      check("single_issue_cnt", 32'(issue_cnt), 32'd1);

      // Streaming, one pair per cycle.
      stalls   = 0;
      base     = issue_cnt;
      in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         in_a = rand_h();
         in_b = rand_h();
         for (int g = 0; g < 50 && !in_ready; g++) begin stalls++; step(); end
         step();
      end
      in_valid = 1'b0;
      check("stream_no_stall", 32'(stalls), 32'd0);
      wait_idle(50);
      check("stream_issue_cnt", 32'(issue_cnt - base), 32'd1000);
      check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: 12 attempted pushes with out_ready low.
      base      = issue_cnt;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      accepts   = 0;
      for (int i = 0; i < 12; i++) begin
         in_a = rand_h();
         in_b = rand_h();
         if (in_ready) accepts++;
         step();
      end
      in_valid = 1'b0;
      step();
      check("bp_accepts", 32'(accepts), 32'd8);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_issues", 32'(issue_cnt - base), 32'd4);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sb_depth", 32'(exp_q.size()), 32'd8);
      n_out     = 0;
      out_ready = 1'b1;
      wait_idle(60);
      check("bp_drained", 32'(n_out), 32'd8);
      check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

      // Toggling out_ready, random in_valid.
      for (int i = 0; i < 300; i++) begin
         out_ready = ~out_ready;
         in_valid  = 1'($urandom_range(1));
         in_a      = rand_h();
         in_b      = rand_h();
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle(100);
      check("toggle_sb_empty", 32'(exp_q.size()), 32'd0);
      check("toggle_issue_cnt", 32'(issue_cnt), 32'(exp_issue));

      // +Inf + 1.0
      single_op(16'h7C00, 16'h3C00, 16'h7C00, 1'b1);

      // Reset while pairs are queued and in flight.
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_a = rand_h();
         in_b = rand_h();
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
      check("midrst_add_a", 32'(add_a), 32'd0);
      step();
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) stale++;
         step();
      end
      check("midrst_no_stale", 32'(stale), 32'd0);
      single_op(16'h3C00, 16'h4000, 16'h4200, 1'b0);
      check("post_rst_issue_cnt", 32'(issue_cnt), 32'd1);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
